// File: rtl/display_share_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : display_share_pkg
// Brief    : Shared types and constants for the display share arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package display_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHOW_A = 2'd1,
        ST_SHOW_B = 2'd2,
        ST_BLANK  = 2'd3
    } state_t;

    localparam logic c_OWNER_A = 1'b0;
    localparam logic c_OWNER_B = 1'b1;

    localparam int unsigned c_DWELL_TICKS_DEFAULT = 32'd200_000_000;
    localparam int unsigned c_BLANK_TICKS_DEFAULT = 32'd10_000_000;

    // One counter width serves both timers so they can share the sub-module.
    function automatic int unsigned timer_width(input int unsigned dwell,
                                                input int unsigned blank);
        int unsigned m;
        m = (dwell > blank) ? dwell : blank;
        return $clog2(m + 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_share_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : display_share_timer
// Brief    : Saturating up-counter with clear, enable and terminal count.
// Revision : 1.0 - initial release
// ============================================================================
module display_share_timer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LIMIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam logic [WIDTH-1:0] c_LIMIT = WIDTH'(LIMIT);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_enable) begin
            if (i_clear) begin
                r_count <= '0;
            end else if (r_count != c_LIMIT) begin
                r_count <= r_count + WIDTH'(1);
            end
        end
    end

    assign o_terminal = (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/display_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : display_share_arbiter
// Brief    : Round-robin time-share of the 7-segment display between two
//            32-bit sources, with minimum dwell and a blanking gap.
//            Optional: DISPLAY_SHARE_PREEMPT_EN lets Req_b preempt owner A.
// Revision : 1.0 - initial release
// ============================================================================
module display_share_arbiter
    import display_share_pkg::*;
#(
    parameter int unsigned DWELL_TICKS = c_DWELL_TICKS_DEFAULT,
    parameter int unsigned BLANK_TICKS = c_BLANK_TICKS_DEFAULT
) (
    input  logic        Clock_100MHz,
    input  logic        Clear_n,
    input  logic        Enable,
    input  logic        Req_a,
    input  logic        Req_b,
    input  logic [31:0] Value_a,
    input  logic [31:0] Value_b,
    output logic        Grant_a,
    output logic        Grant_b,
    output logic [31:0] Display_value,
    output logic        Blank
);

    localparam int unsigned c_TIMER_W = timer_width(DWELL_TICKS, BLANK_TICKS);

    state_t      r_state;
    logic        r_last;
    logic        r_grant_a;
    logic        r_grant_b;
    logic        r_blank;
    logic [31:0] r_display;

    logic w_dwell_done;
    logic w_blank_done;
    logic w_arb_valid;
    logic w_arb_a;
    logic w_leave_a;
    logic w_leave_b;
    logic w_dwell_clear;
    logic w_blank_clear;

    // Dwell counts the owner's hold time; the blank timer stops one short so
    // BLANK lasts exactly BLANK_TICKS cycles.
    assign w_dwell_clear = (r_state != ST_SHOW_A) && (r_state != ST_SHOW_B);
    assign w_blank_clear = (r_state != ST_BLANK);

    display_share_timer #(
        .WIDTH (c_TIMER_W),
        .LIMIT (DWELL_TICKS)
    ) u_dwell_timer (
        .clk        (Clock_100MHz),
        .rst_n      (Clear_n),
        .i_clear    (w_dwell_clear),
        .i_enable   (Enable),
        .o_terminal (w_dwell_done)
    );

    display_share_timer #(
        .WIDTH (c_TIMER_W),
        .LIMIT (BLANK_TICKS - 32'd1)
    ) u_blank_timer (
        .clk        (Clock_100MHz),
        .rst_n      (Clear_n),
        .i_clear    (w_blank_clear),
        .i_enable   (Enable),
        .o_terminal (w_blank_done)
    );

    // On a tie the requester that did not own the display last wins.
    assign w_arb_valid = Req_a | Req_b;
    assign w_arb_a     = Req_a & (~Req_b | (r_last == c_OWNER_B));

`ifdef DISPLAY_SHARE_PREEMPT_EN
    assign w_leave_a = !Req_a || Req_b;
`else
    assign w_leave_a = !Req_a || (w_dwell_done && Req_b);
`endif
    assign w_leave_b = !Req_b || (w_dwell_done && Req_a);

    always_ff @(posedge Clock_100MHz or negedge Clear_n) begin
        if (!Clear_n) begin
            r_state   <= ST_IDLE;
            r_last    <= c_OWNER_B;
            r_grant_a <= 1'b0;
            r_grant_b <= 1'b0;
            r_blank   <= 1'b1;
            r_display <= '0;
        end else if (Enable) begin
            case (r_state)
                ST_IDLE, ST_BLANK: begin
                    if ((r_state == ST_IDLE) || w_blank_done) begin
                        if (w_arb_valid && w_arb_a) begin
                            r_state   <= ST_SHOW_A;
                            r_last    <= c_OWNER_A;
                            r_grant_a <= 1'b1;
                            r_blank   <= 1'b0;
                            r_display <= Value_a;
                        end else if (w_arb_valid) begin
                            r_state   <= ST_SHOW_B;
                            r_last    <= c_OWNER_B;
                            r_grant_b <= 1'b1;
                            r_blank   <= 1'b0;
                            r_display <= Value_b;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_SHOW_A: begin
                    if (w_leave_a) begin
                        r_state   <= ST_BLANK;
                        r_grant_a <= 1'b0;
                        r_blank   <= 1'b1;
                        r_display <= '0;
                    end else begin
                        r_display <= Value_a;
                    end
                end
                ST_SHOW_B: begin
                    if (w_leave_b) begin
                        r_state   <= ST_BLANK;
                        r_grant_b <= 1'b0;
                        r_blank   <= 1'b1;
                        r_display <= '0;
                    end else begin
                        r_display <= Value_b;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Grant_a       = r_grant_a;
    assign Grant_b       = r_grant_b;
    assign Blank         = r_blank;
    assign Display_value = r_display;

endmodule
`default_nettype wire

// File: tb/tb_display_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_display_share_arbiter
// Brief    : Directed self-checking bench, DWELL_TICKS = 8, BLANK_TICKS = 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_share_arbiter;

    logic        clk     = 1'b0;
    logic        clear_n = 1'b1;
    logic        enable  = 1'b1;
    logic        req_a   = 1'b0;
    logic        req_b   = 1'b0;
    logic [31:0] value_a = '0;
    logic [31:0] value_b = '0;
    logic        grant_a;
    logic        grant_b;
    logic        blank;
    logic [31:0] display_value;

    int total = 0;
    int bad   = 0;

    display_share_arbiter #(
        .DWELL_TICKS (8),
        .BLANK_TICKS (3)
    ) dut (
        .Clock_100MHz  (clk),
        .Clear_n       (clear_n),
        .Enable        (enable),
        .Req_a         (req_a),
        .Req_b         (req_b),
        .Value_a       (value_a),
        .Value_b       (value_b),
        .Grant_a       (grant_a),
        .Grant_b       (grant_b),
        .Display_value (display_value),
        .Blank         (blank)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req_a   = 1'b0;
        req_b   = 1'b0;
        enable  = 1'b1;
        clear_n = 1'b0;
        tick(2);
        clear_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        #2 clear_n = 1'b0;
        #1;
        total++;
        if ({grant_a, grant_b, blank} !== 3'b001 || display_value !== 32'h0) begin
            bad++;
            $display("FAIL reset_values: ga/gb/blank=%b%b%b disp=%h want 001 disp=0",
                     grant_a, grant_b, blank, display_value);
        end
        tick(1);
        clear_n = 1'b1;
        tick(3);
        total++;
        if ({grant_a, grant_b, blank} !== 3'b001 || display_value !== 32'h0) begin
            bad++;
            $display("FAIL idle_no_req: ga/gb/blank=%b%b%b disp=%h want 001 disp=0",
                     grant_a, grant_b, blank, display_value);
        end
    endtask

    task automatic test_single_grant();
        apply_reset();
        value_a = 32'h0000_00AB;
        req_a   = 1'b1;
        tick(1);
        total++;
        if ({grant_a, grant_b, blank} !== 3'b100 || display_value !== 32'h0000_00AB) begin
            bad++;
            $display("FAIL first_grant: ga/gb/blank=%b%b%b disp=%h want 100 disp=000000ab",
                     grant_a, grant_b, blank, display_value);
        end
        value_a = 32'h0000_1234;
        tick(1);
        total++;
        if (display_value !== 32'h0000_1234) begin
            bad++;
            $display("FAIL live_track: disp=%h want 00001234", display_value);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        value_a = 32'hA0A0_0001;
        value_b = 32'hB0B0_0002;
        req_a   = 1'b1;
        req_b   = 1'b1;
        tick(1);
        total++;
        if ({grant_a, grant_b, blank} !== 3'b100 || display_value !== 32'hA0A0_0001) begin
            bad++;
            $display("FAIL rr_tie_a: ga/gb/blank=%b%b%b disp=%h want 100 disp=a0a00001",
                     grant_a, grant_b, blank, display_value);
        end
        tick(8);
        total++;
        if ({grant_a, grant_b, blank} !== 3'b100) begin
            bad++;
            $display("FAIL rr_a_dwell_end: ga/gb/blank=%b%b%b want 100", grant_a, grant_b, blank);
        end
        tick(1);
        total++;
        if ({grant_a, grant_b, blank} !== 3'b001 || display_value !== 32'h0) begin
            bad++;
            $display("FAIL rr_blank1: ga/gb/blank=%b%b%b disp=%h want 001 disp=0",
                     grant_a, grant_b, blank, display_value);
        end
        tick(2);
        total++;
        if ({grant_a, grant_b, blank} !== 3'b001) begin
            bad++;
            $display("FAIL rr_blank3: ga/gb/blank=%b%b%b want 001", grant_a, grant_b, blank);
        end
        tick(1);
        total++;
        if ({grant_a, grant_b, blank} !== 3'b010 || display_value !== 32'hB0B0_0002) begin
            bad++;
            $display("FAIL rr_grant_b: ga/gb/blank=%b%b%b disp=%h want 010 disp=b0b00002",
                     grant_a, grant_b, blank, display_value);
        end
        tick(8);
        total++;
        if ({grant_a, grant_b, blank} !== 3'b010) begin
            bad++;
            $display("FAIL rr_b_dwell_end: ga/gb/blank=%b%b%b want 010", grant_a, grant_b, blank);
        end
        tick(1);
        total++;
        if ({grant_a, grant_b, blank} !== 3'b001) begin
            bad++;
            $display("FAIL rr_blank_b2a: ga/gb/blank=%b%b%b want 001", grant_a, grant_b, blank);
        end
        tick(3);
        total++;
        if ({grant_a, grant_b, blank} !== 3'b100 || display_value !== 32'hA0A0_0001) begin
            bad++;
            $display("FAIL rr_regrant_a: ga/gb/blank=%b%b%b disp=%h want 100 disp=a0a00001",
                     grant_a, grant_b, blank, display_value);
        end
    endtask

    task automatic test_drop();
        apply_reset();
        req_a = 1'b1;
        tick(2);
        req_a = 1'b0;
        tick(1);
        total++;
        if ({grant_a, grant_b, blank} !== 3'b001) begin
            bad++;
            $display("FAIL drop_blank: ga/gb/blank=%b%b%b want 001", grant_a, grant_b, blank);
        end
        tick(3);
        total++;
        if ({grant_a, grant_b, blank} !== 3'b001 || display_value !== 32'h0) begin
            bad++;
            $display("FAIL drop_idle: ga/gb/blank=%b%b%b disp=%h want 001 disp=0",
                     grant_a, grant_b, blank, display_value);
        end
        value_b = 32'h0000_0B0B;
        req_b   = 1'b1;
        tick(1);
        total++;
        if ({grant_a, grant_b, blank} !== 3'b010 || display_value !== 32'h0000_0B0B) begin
            bad++;
            $display("FAIL drop_idle_to_b: ga/gb/blank=%b%b%b disp=%h want 010 disp=00000b0b",
                     grant_a, grant_b, blank, display_value);
        end
    endtask

    task automatic test_sole_owner();
        apply_reset();
        req_a = 1'b1;
        tick(1);
        for (int i = 0; i < 50; i++) begin
            total++;
            if ({grant_a, grant_b, blank} !== 3'b100) begin
                bad++;
                $display("FAIL sole_owner cycle %0d: ga/gb/blank=%b%b%b want 100",
                         i, grant_a, grant_b, blank);
            end
            tick(1);
        end
    endtask

    task automatic test_enable_freeze();
        apply_reset();
        value_a = 32'h0000_0011;
        req_a   = 1'b1;
        req_b   = 1'b1;
        tick(4);
        enable  = 1'b0;
        value_a = 32'h0000_0022;
        tick(5);
        total++;
        if ({grant_a, grant_b, blank} !== 3'b100 || display_value !== 32'h0000_0011) begin
            bad++;
            $display("FAIL freeze_hold: ga/gb/blank=%b%b%b disp=%h want 100 disp=00000011",
                     grant_a, grant_b, blank, display_value);
        end
        enable = 1'b1;
        tick(5);
        total++;
        if ({grant_a, grant_b, blank} !== 3'b100 || display_value !== 32'h0000_0022) begin
            bad++;
            $display("FAIL freeze_late_dwell: ga/gb/blank=%b%b%b disp=%h want 100 disp=00000022",
                     grant_a, grant_b, blank, display_value);
        end
        tick(1);
        total++;
        if ({grant_a, grant_b, blank} !== 3'b001) begin
            bad++;
            $display("FAIL freeze_blank: ga/gb/blank=%b%b%b want 001", grant_a, grant_b, blank);
        end
        tick(3);
        total++;
        if ({grant_a, grant_b, blank} !== 3'b010) begin
            bad++;
            $display("FAIL freeze_grant_b: ga/gb/blank=%b%b%b want 010", grant_a, grant_b, blank);
        end
    endtask

    task automatic test_clear();
        apply_reset();
        value_a = 32'h0000_00CC;
        req_a   = 1'b1;
        req_b   = 1'b1;
        tick(4);
        #2 clear_n = 1'b0;
        #1;
        total++;
        if ({grant_a, grant_b, blank} !== 3'b001 || display_value !== 32'h0) begin
            bad++;
            $display("FAIL clear_mid_show: ga/gb/blank=%b%b%b disp=%h want 001 disp=0",
                     grant_a, grant_b, blank, display_value);
        end
        tick(1);
        clear_n = 1'b1;
        tick(10);
        #2 clear_n = 1'b0;
        #1;
        total++;
        if ({grant_a, grant_b, blank} !== 3'b001 || display_value !== 32'h0) begin
            bad++;
            $display("FAIL clear_mid_blank: ga/gb/blank=%b%b%b disp=%h want 001 disp=0",
                     grant_a, grant_b, blank, display_value);
        end
        tick(1);
        clear_n = 1'b1;
        tick(1);
        total++;
        if ({grant_a, grant_b, blank} !== 3'b100) begin
            bad++;
            $display("FAIL clear_last_reset: ga/gb/blank=%b%b%b want 100", grant_a, grant_b, blank);
        end
    endtask

    task automatic test_preempt();
        apply_reset();
        req_a = 1'b1;
        tick(2);
        req_b = 1'b1;
        tick(1);
        total++;
        if ({grant_a, grant_b, blank} !== 3'b001) begin
            bad++;
            $display("FAIL preempt_blank: ga/gb/blank=%b%b%b want 001", grant_a, grant_b, blank);
        end
        tick(3);
        total++;
        if ({grant_a, grant_b, blank} !== 3'b010) begin
            bad++;
            $display("FAIL preempt_grant_b: ga/gb/blank=%b%b%b want 010", grant_a, grant_b, blank);
        end
        tick(8);
        total++;
        if ({grant_a, grant_b, blank} !== 3'b010) begin
            bad++;
            $display("FAIL preempt_b_dwell: ga/gb/blank=%b%b%b want 010", grant_a, grant_b, blank);
        end
        tick(1);
        total++;
        if ({grant_a, grant_b, blank} !== 3'b001) begin
            bad++;
            $display("FAIL preempt_b_release: ga/gb/blank=%b%b%b want 001", grant_a, grant_b, blank);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_grant();
        test_drop();
        test_sole_owner();
        test_clear();
`ifdef DISPLAY_SHARE_PREEMPT_EN
        test_preempt();
`else
        test_round_robin();
        test_enable_freeze();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
